// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: execute-side request/response and data-memory bus bundles.
// master drives the request; slave answers it.
interface lsu_req_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between execute and the data-memory port.
// Define MISALIGNED_SPLIT_EN to split line-crossing accesses in two beats.
module lsu_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int BW = 2 * NB;
`ifdef MISALIGNED_SPLIT_EN
  localparam int  WW    = 2 * XLEN;
  localparam bit  SPLIT = 1'b1;
`else
  localparam bit  SPLIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
  } state_t;

  state_t state, state_n;

  logic              we_q;
  logic              sext_q;
  logic              err_q;
  logic [OW-1:0]     off_q;
  logic [3:0]        size_q;
  logic [ADDR_W-1:0] base_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rd0_q;
`ifdef MISALIGNED_SPLIT_EN
  logic              split_q;
  logic [XLEN-1:0]   rd1_q;
`endif

  logic [3:0]    d_size;
  logic [OW-1:0] d_off;
  logic [4:0]    d_end;
  logic          d_ill;
  logic          d_cross;
  logic          d_err;
  logic          d_sext;

  always_comb begin
    d_size  = 4'd1 << req.req_funct3[1:0];
    d_off   = req.req_addr[OW-1:0];
    d_end   = 5'(d_off) + 5'(d_size);
    d_cross = d_end > 5'(NB);
    d_ill   = (req.req_funct3 == 3'b111)
           || (req.req_we && req.req_funct3[2])
           || ((XLEN == 32)
               && (req.req_funct3 == 3'b011
                || req.req_funct3 == 3'b110));
    d_err   = d_ill || (d_cross && !SPLIT);
    d_sext  = !req.req_funct3[2]
           && (req.req_funct3[1:0] != 2'b11);
  end

  // Lane placement of the access window
  logic [NB-1:0]   be0;
  logic [XLEN-1:0] wd0;
`ifdef MISALIGNED_SPLIT_EN
  logic [NB-1:0]   be1;
  logic [XLEN-1:0] wd1;
  logic [BW-1:0]   be_win;
  logic [WW-1:0]   wd_win;

  assign be_win = ((BW'(1) << size_q) - BW'(1)) << off_q;
  assign wd_win = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
  assign be0    = be_win[NB-1:0];
  assign be1    = be_win[BW-1:NB];
  assign wd0    = wd_win[XLEN-1:0];
  assign wd1    = wd_win[WW-1:XLEN];
`else
  assign be0 = NB'(((BW'(1) << size_q) - BW'(1)) << off_q);
  assign wd0 = wdata_q << {off_q, 3'b000};
`endif

  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] ld_mask;
  logic [XLEN-1:0] ld_res;
  logic            ld_sbit;

  // A shift of XLEN or more empties the one, so a full-width mask is all ones
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    ld_val  = XLEN'({rd1_q, rd0_q} >> {off_q, 3'b000});
`else
    ld_val  = rd0_q >> {off_q, 3'b000};
`endif
    ld_mask = (XLEN'(1) << {size_q, 3'b000}) - XLEN'(1);
    ld_sbit = |(ld_val & (ld_mask ^ (ld_mask >> 1)));
    ld_res  = (sext_q && ld_sbit) ? (ld_val | ~ld_mask)
                                  : (ld_val & ld_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split_q <= 1'b0;
      rd1_q   <= '0;
`endif
    end else begin
      if (state == IDLE && req.req_valid) begin
        we_q    <= req.req_we;
        sext_q  <= d_sext;
        err_q   <= d_err;
        off_q   <= d_off;
        size_q  <= d_size;
        base_q  <= {req.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        wdata_q <= req.req_wdata;
        rd0_q   <= '0;
`ifdef MISALIGNED_SPLIT_EN
        split_q <= d_cross;
        rd1_q   <= '0;
`endif
      end
      if (state == WAIT0 && mem.mem_rvalid) begin
        rd0_q <= mem.mem_rdata;
      end
`ifdef MISALIGNED_SPLIT_EN
      if (state == WAIT1 && mem.mem_rvalid) begin
        rd1_q <= mem.mem_rdata;
      end
`endif
    end
  end

  always_comb begin
    state_n         = state;
    req.req_ready   = 1'b0;
    req.resp_valid  = 1'b0;
    req.resp_rdata  = '0;
    req.resp_err    = 1'b0;
    mem.mem_req     = 1'b0;
    mem.mem_we      = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_be      = '0;
    mem.mem_wdata   = '0;
    unique case (state)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          state_n = d_err ? RESP : REQ0;
        end
      end
      REQ0: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base_q;
        mem.mem_be    = be0;
        mem.mem_wdata = we_q ? wd0 : '0;
        if (mem.mem_gnt) begin
`ifdef MISALIGNED_SPLIT_EN
          if (!we_q)        state_n = WAIT0;
          else if (split_q) state_n = REQ1;
          else              state_n = RESP;
`else
          state_n = we_q ? RESP : WAIT0;
`endif
        end
      end
      WAIT0: begin
        if (mem.mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
          state_n = split_q ? REQ1 : RESP;
`else
          state_n = RESP;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      REQ1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base_q + ADDR_W'(NB);
        mem.mem_be    = be1;
        mem.mem_wdata = we_q ? wd1 : '0;
        if (mem.mem_gnt) begin
          state_n = we_q ? RESP : WAIT1;
        end
      end
      WAIT1: begin
        if (mem.mem_rvalid) begin
          state_n = RESP;
        end
      end
`endif
      RESP: begin
        req.resp_valid = 1'b1;
        req.resp_err   = err_q;
        req.resp_rdata = (we_q || err_q) ? '0 : ld_res;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
